sync_decoder: RTL and testbench

//  Receiving end of the LSPC video timing: samples HSYNC/VSYNC/CHBL as produced by the

---
 rtl/sync_decoder.sv | 193 +++++++++++++++++++
 tb/tb_sync_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_decoder.sv
// Recovers pixel/line position, raster geometry, PAL/NTSC mode and a lock flag
// from the LSPC HSYNC/VSYNC/CHBL outputs, sampled on the 6 MHz pixel enable.
//
// state      | meaning
// ST_SEARCH  | waiting for the first frame start; the partial frame is not measured
// ST_ACQUIRE | counting consecutive identical, internally consistent frames
// ST_LOCKED  | raster stable; any differing frame or missing HSYNC drops lock
module sync_decoder #(
    parameter int LOCK_FRAMES = 2,
    parameter int H_TIMEOUT   = 1023,
    parameter int PAL_THRESH  = 288
) (
    input  logic       clk_24mb,
    input  logic       resetp,
    input  logic       pix_ce,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       chbl,
    output logic [8:0] h_pos,
    output logic [8:0] v_pos,
    output logic       de,
    output logic [9:0] line_len,
    output logic [8:0] frame_lines,
    output logic       pal_det,
    output logic       locked,
    output logic       new_line,
    output logic       new_frame
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_t;

    localparam int            MW         = (LOCK_FRAMES > 2) ? $clog2(LOCK_FRAMES) : 1;
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_FRAMES - 1);
    localparam logic [9:0]    TO_LOAD    = 10'(H_TIMEOUT);

    lock_state_t   state;
    logic [MW-1:0] match_cnt;

    logic       hs_q;
    logic       vs_q;
    logic       chbl_q;
    logic       vs_pend;
    logic [9:0] h_cnt;
    logic [9:0] to_cnt;
    logic [9:0] ref_len;
    logic       ref_valid;
    logic       line_mm;

    logic       hs_fall;
    logic       vs_fall;
    logic       frame_start;
    logic       timeout;
    logic       line_bad;
    logic       frame_bad;
    logic       lock_drop;
    logic [9:0] len_meas;
    logic [9:0] new_len;
    logic [8:0] lines_meas;

    assign hs_fall     = pix_ce & hs_q & ~hsync;
    assign vs_fall     = pix_ce & vs_q & ~vsync;
    assign frame_start = hs_fall & (vs_pend | vs_fall);
    assign timeout     = pix_ce & ~hs_fall & (to_cnt == 10'd1);

    assign len_meas   = (h_cnt == 10'd1023) ? 10'd1023 : h_cnt + 10'd1;
    assign lines_meas = (v_pos == 9'd511) ? 9'd511 : v_pos + 9'd1;

    // The fall that starts a frame also closes the last line of the old frame,
    // so its measurement still takes part in the old frame's consistency check.
    assign line_bad  = ref_valid & (len_meas != ref_len);
    assign new_len   = ref_valid ? ref_len : len_meas;
    assign frame_bad = line_mm | line_bad | (new_len != line_len) | (lines_meas != frame_lines);
    assign lock_drop = timeout | (frame_start & (state == ST_LOCKED) & frame_bad);

    always_ff @(posedge clk_24mb or negedge resetp) begin
        if (!resetp) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            chbl_q    <= 1'b0;
            vs_pend   <= 1'b0;
            h_cnt     <= 10'd0;
            h_pos     <= 9'd0;
            v_pos     <= 9'd0;
            to_cnt    <= 10'd0;
            ref_len   <= 10'd0;
            ref_valid <= 1'b0;
            line_mm   <= 1'b0;
            new_line  <= 1'b0;
            new_frame <= 1'b0;
            de        <= 1'b0;
        end else if (pix_ce) begin
            hs_q      <= hsync;
            vs_q      <= vsync;
            chbl_q    <= chbl;
            new_line  <= hs_fall;
            new_frame <= frame_start;
            de        <= locked & ~lock_drop & ~chbl_q;

            if (hs_fall) begin
                h_cnt <= 10'd0;
                h_pos <= 9'd0;
            end else begin
                if (h_cnt != 10'd1023)
                    h_cnt <= h_cnt + 10'd1;
                if (h_pos != 9'd511)
                    h_pos <= h_pos + 9'd1;
            end

            // Loss-of-sync timer: reloads on every HSYNC fall, idles at zero.
            if (hs_fall)
                to_cnt <= TO_LOAD;
            else if (to_cnt != 10'd0)
                to_cnt <= to_cnt - 10'd1;

            if (frame_start || timeout)
                vs_pend <= 1'b0;
            else if (vs_fall)
                vs_pend <= 1'b1;

            if (frame_start)
                v_pos <= 9'd0;
            else if (hs_fall && v_pos != 9'd511)
                v_pos <= v_pos + 9'd1;

            if (frame_start) begin
                ref_valid <= 1'b0;
                line_mm   <= 1'b0;
            end else if (hs_fall) begin
                if (!ref_valid) begin
                    ref_len   <= len_meas;
                    ref_valid <= 1'b1;
                end else if (line_bad) begin
                    line_mm <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_24mb or negedge resetp) begin
        if (!resetp) begin
            state       <= ST_SEARCH;
            match_cnt   <= '0;
            locked      <= 1'b0;
            line_len    <= 10'd0;
            frame_lines <= 9'd0;
            pal_det     <= 1'b0;
        end else if (timeout) begin
            state     <= ST_SEARCH;
            match_cnt <= '0;
            locked    <= 1'b0;
        end else if (frame_start) begin
            if (state != ST_SEARCH) begin
                line_len    <= new_len;
                frame_lines <= lines_meas;
                pal_det     <= (32'(lines_meas) >= 32'(PAL_THRESH));
            end
            case (state)
                ST_SEARCH: begin
                    state     <= ST_ACQUIRE;
                    match_cnt <= '0;
                end
                ST_ACQUIRE: begin
                    if (frame_bad) begin
                        match_cnt <= '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        state     <= ST_LOCKED;
                        match_cnt <= '0;
                        locked    <= 1'b1;
                    end else begin
                        match_cnt <= match_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (frame_bad) begin
                        state     <= ST_ACQUIRE;
                        match_cnt <= '0;
                        locked    <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_SEARCH;
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_decoder.sv
// Directed bench for sync_decoder: a compact raster generator (6-tick lines so
// whole frames stay cheap) drives lock, mismatch, same-tick, timeout and reset cases.
module tb_sync_decoder;

    logic       clk = 1'b0;
    logic       resetp;
    logic       pix_ce;
    logic       hsync;
    logic       vsync;
    logic       chbl;
    logic [8:0] h_pos;
    logic [8:0] v_pos;
    logic       de;
    logic [9:0] line_len;
    logic [8:0] frame_lines;
    logic       pal_det;
    logic       locked;
    logic       new_line;
    logic       new_frame;

    int n_cmp = 0;
    int n_err = 0;

    // raster generator state
    localparam int W = 6;
    int n_lines   = 264;
    int ln        = 0;
    int px        = 0;
    int cur_ln    = 0;
    int cur_px    = 0;
    int short_ln  = -1;
    bit same_mode = 1'b0;
    bit hold      = 1'b0;

    sync_decoder dut (
        .clk_24mb   (clk),
        .resetp     (resetp),
        .pix_ce     (pix_ce),
        .hsync      (hsync),
        .vsync      (vsync),
        .chbl       (chbl),
        .h_pos      (h_pos),
        .v_pos      (v_pos),
        .de         (de),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .pal_det    (pal_det),
        .locked     (locked),
        .new_line   (new_line),
        .new_frame  (new_frame)
    );

    always #5 clk = ~clk;

    task automatic tick();
        int len;
        @(negedge clk);
        if (hold) begin
            hsync = 1'b1;
            vsync = 1'b1;
            chbl  = 1'b0;
        end else begin
            hsync = (px >= 2);
            if (same_mode)
                vsync = (ln >= 2);
            else
                vsync = !((ln == n_lines - 1 && px >= 3) || ln < 2);
            chbl = (px < 2);
        end
        cur_ln = ln;
        cur_px = px;
        pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        if (!hold) begin
            len = (ln == short_ln) ? W - 1 : W;
            px++;
            if (px >= len) begin
                px = 0;
                ln++;
                if (ln >= n_lines) ln = 0;
            end
        end
    endtask

    task automatic run_until(input int tln, input int tpx);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(cur_ln == tln && cur_px == tpx) && n < 20000);
        if (!(cur_ln == tln && cur_px == tpx)) begin
            $display("FAIL run_until_timeout: reached line %0d px %0d, required line %0d px %0d", cur_ln, cur_px, tln, tpx);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic do_reset(input int lines);
        resetp = 1'b0; pix_ce = 1'b0; hsync = 1'b1; vsync = 1'b1; chbl = 1'b0;
        hold = 1'b0; same_mode = 1'b0; short_ln = -1;
        n_lines = lines; ln = lines - 2; px = 0;
        repeat (3) @(negedge clk);
        resetp = 1'b1;
    endtask

    task automatic test_reset();
        resetp = 1'b0; pix_ce = 1'b0; hsync = 1'b1; vsync = 1'b1; chbl = 1'b0;
        repeat (2) @(negedge clk);
        if (h_pos !== 9'd0) begin $display("FAIL rst_h_pos: got %0d want 0", h_pos); n_err++; end n_cmp++;
        if (v_pos !== 9'd0) begin $display("FAIL rst_v_pos: got %0d want 0", v_pos); n_err++; end n_cmp++;
        if (line_len !== 10'd0 || frame_lines !== 9'd0) begin
            $display("FAIL rst_geom: got %0d/%0d want 0/0", line_len, frame_lines); n_err++; end n_cmp++;
        if ({de, pal_det, locked, new_line, new_frame} !== 5'b0) begin
            $display("FAIL rst_flags: got %b want 00000", {de, pal_det, locked, new_line, new_frame}); n_err++; end n_cmp++;
    endtask

    task automatic test_ntsc_lock();
        do_reset(264);
        run_until(0, 0);
        if (new_frame !== 1'b1) begin $display("FAIL fs1_new_frame: got %b want 1", new_frame); n_err++; end n_cmp++;
        if (v_pos !== 9'd0 || h_pos !== 9'd0) begin $display("FAIL fs1_pos: got %0d,%0d want 0,0", h_pos, v_pos); n_err++; end n_cmp++;
        if (line_len !== 10'd0) begin $display("FAIL fs1_no_latch: got %0d want 0", line_len); n_err++; end n_cmp++;
        if (locked !== 1'b0) begin $display("FAIL fs1_locked: got %b want 0", locked); n_err++; end n_cmp++;
        tick();
        if (new_frame !== 1'b0 || h_pos !== 9'd1) begin
            $display("FAIL fs1_next_tick: got nf=%b h=%0d want nf=0 h=1", new_frame, h_pos); n_err++; end n_cmp++;
        run_until(0, 0);
        if (line_len !== 10'd6) begin $display("FAIL fs2_line_len: got %0d want 6", line_len); n_err++; end n_cmp++;
        if (frame_lines !== 9'd264) begin $display("FAIL fs2_frame_lines: got %0d want 264", frame_lines); n_err++; end n_cmp++;
        if (pal_det !== 1'b0) begin $display("FAIL fs2_pal: got %b want 0", pal_det); n_err++; end n_cmp++;
        if (locked !== 1'b0) begin $display("FAIL fs2_locked: got %b want 0", locked); n_err++; end n_cmp++;
        run_until(0, 0);
        if (locked !== 1'b0) begin $display("FAIL fs3_locked: got %b want 0", locked); n_err++; end n_cmp++;
        if (de !== 1'b0) begin $display("FAIL fs3_de_unlocked: got %b want 0", de); n_err++; end n_cmp++;
        run_until(0, 0);
        if (locked !== 1'b1) begin $display("FAIL fs4_locked: got %b want 1", locked); n_err++; end n_cmp++;
        run_until(10, 0);
        if (new_line !== 1'b1 || v_pos !== 9'd10) begin
            $display("FAIL line10: got nl=%b v=%0d want nl=1 v=10", new_line, v_pos); n_err++; end n_cmp++;
        tick();
        if (new_line !== 1'b0) begin $display("FAIL nl_pulse: got %b want 0", new_line); n_err++; end n_cmp++;
        tick();
        if (de !== 1'b0) begin $display("FAIL de_blank: got %b want 0", de); n_err++; end n_cmp++;
        tick();
        if (de !== 1'b1 || h_pos !== 9'd3) begin
            $display("FAIL de_active: got de=%b h=%0d want de=1 h=3", de, h_pos); n_err++; end n_cmp++;
    endtask

    task automatic test_short_line();
        run_until(0, 0);
        short_ln = 50;
        run_until(100, 0);
        short_ln = -1;
        if (locked !== 1'b1 || v_pos !== 9'd100) begin
            $display("FAIL short_midframe: got lk=%b v=%0d want lk=1 v=100", locked, v_pos); n_err++; end n_cmp++;
        run_until(0, 0);
        if (locked !== 1'b0) begin $display("FAIL short_unlock: got %b want 0", locked); n_err++; end n_cmp++;
        if (line_len !== 10'd6 || frame_lines !== 9'd264) begin
            $display("FAIL short_geom: got %0d/%0d want 6/264", line_len, frame_lines); n_err++; end n_cmp++;
        run_until(0, 0);
        if (locked !== 1'b0) begin $display("FAIL short_clean1: got %b want 0", locked); n_err++; end n_cmp++;
        run_until(0, 0);
        if (locked !== 1'b1) begin $display("FAIL short_relock: got %b want 1", locked); n_err++; end n_cmp++;
    endtask

    task automatic test_same_tick();
        run_until(100, 0);
        same_mode = 1'b1;
        run_until(263, 5);
        if (v_pos !== 9'd263 || new_frame !== 1'b0) begin
            $display("FAIL same_pre: got v=%0d nf=%b want v=263 nf=0", v_pos, new_frame); n_err++; end n_cmp++;
        tick();
        if (v_pos !== 9'd0 || new_frame !== 1'b1 || h_pos !== 9'd0) begin
            $display("FAIL same_fs: got v=%0d nf=%b h=%0d want v=0 nf=1 h=0", v_pos, new_frame, h_pos); n_err++; end n_cmp++;
        if (frame_lines !== 9'd264 || locked !== 1'b1) begin
            $display("FAIL same_lines: got %0d lk=%b want 264 lk=1", frame_lines, locked); n_err++; end n_cmp++;
        same_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        run_until(100, 3);
        #2 resetp = 1'b0;
        #1;
        if (locked !== 1'b0 || v_pos !== 9'd0 || h_pos !== 9'd0) begin
            $display("FAIL async_rst_state: got lk=%b v=%0d h=%0d want 0/0/0", locked, v_pos, h_pos); n_err++; end n_cmp++;
        if (line_len !== 10'd0 || frame_lines !== 9'd0 || de !== 1'b0) begin
            $display("FAIL async_rst_geom: got %0d/%0d de=%b want 0/0/0", line_len, frame_lines, de); n_err++; end n_cmp++;
        repeat (2) @(negedge clk);
        resetp = 1'b1;
        run_until(0, 0);
        if (line_len !== 10'd0 || locked !== 1'b0) begin
            $display("FAIL rst_fs1: got len=%0d lk=%b want 0/0", line_len, locked); n_err++; end n_cmp++;
        run_until(0, 0);
        run_until(0, 0);
        if (locked !== 1'b0) begin $display("FAIL rst_fs3: got %b want 0", locked); n_err++; end n_cmp++;
        run_until(0, 0);
        if (locked !== 1'b1) begin $display("FAIL rst_fs4: got %b want 1", locked); n_err++; end n_cmp++;
    endtask

    task automatic test_pal();
        do_reset(312);
        run_until(0, 0);
        run_until(0, 0);
        if (frame_lines !== 9'd312 || pal_det !== 1'b1) begin
            $display("FAIL pal_fs2: got %0d pal=%b want 312 pal=1", frame_lines, pal_det); n_err++; end n_cmp++;
        if (line_len !== 10'd6 || locked !== 1'b0) begin
            $display("FAIL pal_fs2_len: got %0d lk=%b want 6 lk=0", line_len, locked); n_err++; end n_cmp++;
        run_until(0, 0);
        if (locked !== 1'b0) begin $display("FAIL pal_fs3: got %b want 0", locked); n_err++; end n_cmp++;
        run_until(0, 0);
        if (locked !== 1'b1) begin $display("FAIL pal_fs4: got %b want 1", locked); n_err++; end n_cmp++;
    endtask

    task automatic test_timeout();
        run_until(5, 0);
        hold = 1'b1;
        repeat (1022) tick();
        if (locked !== 1'b1 || de !== 1'b1) begin
            $display("FAIL to_1022: got lk=%b de=%b want 1/1", locked, de); n_err++; end n_cmp++;
        if (h_pos !== 9'd511) begin $display("FAIL to_hpos_sat: got %0d want 511", h_pos); n_err++; end n_cmp++;
        tick();
        if (locked !== 1'b0 || de !== 1'b0) begin
            $display("FAIL to_1023: got lk=%b de=%b want 0/0", locked, de); n_err++; end n_cmp++;
        if (h_pos !== 9'd511) begin $display("FAIL to_hpos_hold: got %0d want 511", h_pos); n_err++; end n_cmp++;
        hold = 1'b0;
        run_until(0, 0);
        if (new_frame !== 1'b1 || locked !== 1'b0 || frame_lines !== 9'd312) begin
            $display("FAIL to_research: got nf=%b lk=%b lines=%0d want 1/0/312", new_frame, locked, frame_lines); n_err++; end n_cmp++;
    endtask

    initial begin
        test_reset();
        test_ntsc_lock();
        test_short_line();
        test_same_tick();
        test_reset_mid();
        test_pal();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
